// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Defines the digit type, the blank-digit code, FSM states and a power-of-ten helper.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_BLANK = 4'hF;

    typedef enum logic {
        IDLE,
        SHIFT
    } conv_state_t;

    // 10^n, used to build the largest value that fits in n BCD digits.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Optional leading-zero blanking for the display path: define LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int CMP_W = (WIDTH > 64) ? WIDTH : 64;
    localparam logic [CMP_W-1:0] LIMIT = CMP_W'(pow10(DIGITS) - 64'd1);

    // Reset value matches what a completed conversion of zero would show.
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [4*DIGITS-1:0] BCD_RESET = {(4*DIGITS){1'b1}} << 4;
`else
    localparam logic [4*DIGITS-1:0] BCD_RESET = '0;
`endif

    conv_state_t            state_q, state_d;
    logic [WIDTH-1:0]       shiftReg_q, shiftReg_d;
    logic [4*DIGITS-1:0]    digits_q, digits_d;
    logic [4*DIGITS-1:0]    bcdOut_q, bcdOut_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovfPending_q, ovfPending_d;
    logic                   overflow_q, overflow_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [4*DIGITS-1:0]    digitsAdj;
    logic [4*DIGITS-1:0]    digitsShift;
    logic [4*DIGITS-1:0]    digitsFmt;
    logic [WIDTH-1:0]       shiftNext;
    logic                   unusedCarry;

    for (genvar g = 0; g < DIGITS; g++) begin : gAdd3
        bcd_add3 uAdd3 (
            .digit_i (digits_q[4*g +: 4]),
            .digit_o (digitsAdj[4*g +: 4])
        );
    end

    // Carry out of the top digit is discarded, so overflowing values wrap mod 10^DIGITS.
    assign {unusedCarry, digitsShift, shiftNext} = {digitsAdj, shiftReg_q, 1'b0};

    always_comb begin
        digitsFmt = digitsShift;
`ifdef LEADING_ZERO_BLANK_EN
        begin : blankLeading
            logic leading;
            leading = 1'b1;
            for (int i = DIGITS - 1; i > 0; i--) begin
                if (leading && (digitsFmt[4*i +: 4] == 4'd0)) begin
                    digitsFmt[4*i +: 4] = BCD_BLANK;
                end else begin
                    leading = 1'b0;
                end
            end
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        shiftReg_d   = shiftReg_q;
        digits_d     = digits_q;
        bcdOut_d     = bcdOut_q;
        cnt_d        = cnt_q;
        ovfPending_d = ovfPending_q;
        overflow_d   = overflow_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shiftReg_d   = bin_in;
                    digits_d     = '0;
                    cnt_d        = CNT_W'(WIDTH);
                    ovfPending_d = (CMP_W'(bin_in) > LIMIT);
                    busy_d       = 1'b1;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                digits_d   = digitsShift;
                shiftReg_d = shiftNext;
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcdOut_d   = digitsFmt;
                    overflow_d = ovfPending_q;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shiftReg_q   <= '0;
            digits_q     <= '0;
            bcdOut_q     <= BCD_RESET;
            cnt_q        <= '0;
            ovfPending_q <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shiftReg_q   <= shiftReg_d;
            digits_q     <= digits_d;
            bcdOut_q     <= bcdOut_d;
            cnt_q        <= cnt_d;
            ovfPending_q <= ovfPending_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bcd_out  = bcdOut_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance.
// Expected display codes follow LEADING_ZERO_BLANK_EN when the bench is built with it.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start, start2;
    logic [7:0]  binIn, binIn2;
    logic [11:0] bcdOut;
    logic [7:0]  bcdOut2;
    logic        busy, done, overflow;
    logic        busy2, done2, overflow2;

    int checks = 0;
    int errors = 0;
    int cyc, busyCnt, doneCnt;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [11:0] EXP_ZERO = 12'hFF0;
    localparam logic [11:0] EXP_9    = 12'hFF9;
    localparam logic [11:0] EXP_10   = 12'hF10;
    localparam logic [11:0] EXP_15   = 12'hF15;
    localparam logic [7:0]  EXP2_RST = 8'hF0;
`else
    localparam logic [11:0] EXP_ZERO = 12'h000;
    localparam logic [11:0] EXP_9    = 12'h009;
    localparam logic [11:0] EXP_10   = 12'h010;
    localparam logic [11:0] EXP_15   = 12'h015;
    localparam logic [7:0]  EXP2_RST = 8'h00;
`endif

    logic [7:0]  b2bVals [4];
    logic [11:0] b2bExps [4];

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (binIn),
        .bcd_out  (bcdOut),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .bin_in   (binIn2),
        .bcd_out  (bcdOut2),
        .busy     (busy2),
        .done     (done2),
        .overflow (overflow2)
    );

    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Pulse start for one cycle, then scramble bin_in to show it is not re-sampled.
    task automatic applyStimulus(input bit sel, input logic [7:0] value);
        if (!sel) begin
            start = 1'b1;
            binIn = value;
        end else begin
            start2 = 1'b1;
            binIn2 = value;
        end
        stepCycle();
        start  = 1'b0;
        start2 = 1'b0;
        binIn  = 8'($urandom);
        binIn2 = 8'($urandom);
    endtask

    task automatic waitDone(input bit sel);
        cyc     = 0;
        busyCnt = (sel ? busy2 : busy) ? 1 : 0;
        while (!(sel ? done2 : done) && cyc < 40) begin
            stepCycle();
            cyc++;
            if (sel ? busy2 : busy) busyCnt++;
        end
    endtask

    task automatic countDones(input int n);
        doneCnt = 0;
        for (int i = 0; i < n; i++) begin
            stepCycle();
            if (done) doneCnt++;
        end
    endtask

    initial begin
        b2bVals = '{8'd9, 8'd10, 8'd100, 8'd255};
        b2bExps = '{EXP_9, EXP_10, 12'h100, 12'h255};
        start  = 1'b0;
        start2 = 1'b0;
        binIn  = '0;
        binIn2 = '0;

        repeat (2) stepCycle();
        checkOutput("rst_busy",     16'(busy),     16'd0);
        checkOutput("rst_done",     16'(done),     16'd0);
        checkOutput("rst_overflow", 16'(overflow), 16'd0);
        checkOutput("rst_bcd",      16'(bcdOut),   16'(EXP_ZERO));
        checkOutput("rst_bcd2",     16'(bcdOut2),  16'(EXP2_RST));
        rst_n = 1'b1;
        stepCycle();

        applyStimulus(1'b0, 8'd0);
        waitDone(1'b0);
        checkOutput("zero_latency", 16'(cyc),      16'd8);
        checkOutput("zero_busy",    16'(busyCnt),  16'd8);
        checkOutput("zero_bcd",     16'(bcdOut),   16'(EXP_ZERO));
        checkOutput("zero_ovf",     16'(overflow), 16'd0);
        stepCycle();
        checkOutput("done_width",   16'(done),     16'd0);
        checkOutput("zero_hold",    16'(bcdOut),   16'(EXP_ZERO));

        applyStimulus(1'b0, b2bVals[0]);
        for (int i = 0; i < 4; i++) begin
            waitDone(1'b0);
            checkOutput("b2b_latency", 16'(cyc),     16'd8);
            checkOutput("b2b_bcd",     16'(bcdOut),  16'(b2bExps[i]));
            checkOutput("b2b_ovf",     16'(overflow), 16'd0);
            if (i < 3) applyStimulus(1'b0, b2bVals[i+1]);
        end

        applyStimulus(1'b0, 8'd15);
        stepCycle();
        stepCycle();
        start = 1'b1;
        binIn = 8'd7;
        stepCycle();
        start = 1'b0;
        waitDone(1'b0);
        checkOutput("ign_latency", 16'(cyc),     16'd5);
        checkOutput("ign_busy",    16'(busyCnt), 16'd5);
        checkOutput("ign_bcd",     16'(bcdOut),  16'(EXP_15));
        countDones(12);
        checkOutput("ign_no_extra_done", 16'(doneCnt), 16'd0);
        checkOutput("ign_idle",          16'(busy),    16'd0);

        applyStimulus(1'b1, 8'd42);
        waitDone(1'b1);
        checkOutput("d2_42_latency", 16'(cyc),       16'd8);
        checkOutput("d2_42_bcd",     16'(bcdOut2),   16'h42);
        checkOutput("d2_42_ovf",     16'(overflow2), 16'd0);
        applyStimulus(1'b1, 8'd123);
        waitDone(1'b1);
        checkOutput("d2_123_bcd",    16'(bcdOut2),   16'h23);
        checkOutput("d2_123_ovf",    16'(overflow2), 16'd1);

        applyStimulus(1'b0, 8'd200);
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("mid_busy", 16'(busy), 16'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy",  16'(busy),      16'd0);
        checkOutput("arst_done",  16'(done),      16'd0);
        checkOutput("arst_bcd",   16'(bcdOut),    16'(EXP_ZERO));
        checkOutput("arst_ovf",   16'(overflow),  16'd0);
        checkOutput("arst_bcd2",  16'(bcdOut2),   16'(EXP2_RST));
        checkOutput("arst_ovf2",  16'(overflow2), 16'd0);
        stepCycle();
        rst_n = 1'b1;
        countDones(12);
        checkOutput("arst_no_done", 16'(doneCnt), 16'd0);
        checkOutput("arst_idle",    16'(busy),    16'd0);

        applyStimulus(1'b0, 8'd200);
        waitDone(1'b0);
        checkOutput("post_rst_latency", 16'(cyc),      16'd8);
        checkOutput("post_rst_bcd",     16'(bcdOut),   16'h200);
        checkOutput("post_rst_ovf",     16'(overflow), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
